// File: rtl/dphy_hs_byte_align.sv
// Purpose : byte aligner for one D-PHY HS data lane; finds the SoT sync byte at any of 8 bit offsets.
// Latency : sync seen in window at cycle t -> sot_o/locked_o at t+1, first aligned byte at t+2.
// Backpressure: none; downstream must accept one byte per byte_clk while valid_o is high.
//
// Ports:
//   clk_i      byte clock from the HS clock receiver
//   rst_n_i    asynchronous active-low reset
//   hs_en_i    HS burst active (low = LP state)
//   byte_i     unaligned deserializer word, bit 0 earliest in time
//   byte_o     aligned payload byte (valid_o qualifies it)
//   valid_o    byte_o valid
//   sot_o      one-cycle pulse when sync is found and the burst locks
//   sot_err_o  one-cycle pulse when no sync is seen within SYNC_TIMEOUT bytes
//   locked_o   high while locked to an offset
//   offset_o   bit offset of the last lock (0..7), held until next lock or reset
module dphy_hs_byte_align #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       hs_en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       sot_o,
  output logic       sot_err_o,
  output logic       locked_o,
  output logic [2:0] offset_o
);

  localparam int unsigned CW = (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED, ERR} state_t;

  state_t          state_q;
  logic [7:0]      prev_q;
  logic [CW-1:0]   cnt_q;
  // Set once hs_en_i has been seen low; after reset the lane must pass
  // through LP before a burst is trusted.
  logic            arm_q;
  logic [7:0]      byte_q;
  logic            valid_q;
  logic            sot_q;
  logic            sot_err_q;
  logic            locked_q;
  logic [2:0]      offset_q;

  logic [15:0]     win;
  logic            hit;
  logic [2:0]      hit_k;
  logic [7:0]      aligned;

  // prev_q holds the earlier byte, so it occupies the low half of the window.
  assign win     = {byte_i, prev_q};
  assign aligned = win[offset_q +: 8];

  // Scan from the top so the lowest matching offset is the one left standing.
  always_comb begin
    hit   = 1'b0;
    hit_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_BYTE) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      prev_q    <= 8'h00;
      cnt_q     <= '0;
      arm_q     <= 1'b0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      sot_q     <= 1'b0;
      sot_err_q <= 1'b0;
      locked_q  <= 1'b0;
      offset_q  <= 3'd0;
    end else begin
      sot_q     <= 1'b0;
      sot_err_q <= 1'b0;
      valid_q   <= 1'b0;
      prev_q    <= hs_en_i ? byte_i : 8'h00;

      if (!hs_en_i) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        locked_q <= 1'b0;
        arm_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm_q) begin
              state_q <= HUNT;
              cnt_q   <= '0;
            end
          end
          HUNT: begin
            // A match on the final hunt byte still locks: match beats timeout.
            if (hit) begin
              state_q  <= LOCKED;
              offset_q <= hit_k;
              sot_q    <= 1'b1;
              locked_q <= 1'b1;
              cnt_q    <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q   <= ERR;
              sot_err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          LOCKED: begin
            byte_q  <= aligned;
            valid_q <= 1'b1;
          end
          ERR: begin
            // Parked until the lane returns to LP.
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign byte_o    = byte_q;
  assign valid_o   = valid_q;
  assign sot_o     = sot_q;
  assign sot_err_o = sot_err_q;
  assign locked_o  = locked_q;
  assign offset_o  = offset_q;

endmodule

// File: tb/tb_dphy_hs_byte_align.sv
module tb_dphy_hs_byte_align;

  localparam logic [7:0] SYNC = 8'hB8;
  localparam int         TO   = 16;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       hs_en_i = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic [7:0] byte_o;
  logic       valid_o;
  logic       sot_o;
  logic       sot_err_o;
  logic       locked_o;
  logic [2:0] offset_o;

  dphy_hs_byte_align #(.SYNC_BYTE(SYNC), .SYNC_TIMEOUT(TO)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .hs_en_i  (hs_en_i),
    .byte_i   (byte_i),
    .byte_o   (byte_o),
    .valid_o  (valid_o),
    .sot_o    (sot_o),
    .sot_err_o(sot_err_o),
    .locked_o (locked_o),
    .offset_o (offset_o)
  );

  always #5 clk_i = ~clk_i;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] bq[$];     // bytes of the burst under test, in arrival order
  logic [7:0] outq[$];   // valid bytes observed during the last burst
  int         n_sot, n_err, n_val;
  logic [2:0] exp_off = 3'd0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Eight serial bits starting at absolute bit position p of the burst.
  function automatic logic [7:0] sbyte(input int p);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    for (int b = 0; b < 8; b++) begin
      t    = bq[(p + b) / 8];
      r[b] = t[(p + b) % 8];
    end
    return r;
  endfunction

  task automatic put_sync(input int p);
    logic [7:0] s;
    logic [7:0] t;
    s = SYNC;
    for (int b = 0; b < 8; b++) begin
      t = bq[(p + b) / 8];
      t[(p + b) % 8] = s[b];
      bq[(p + b) / 8] = t;
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input logic en, input logic [7:0] b);
    hs_en_i = en;
    byte_i  = b;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Reference: the first hunt window pairs burst bytes 0 and 1, so at burst
  // cycle i the window covers serial bits 8(i-1)..8i+7. Search windows 1..TO
  // for the earliest-in-time sync; the aligned stream then starts at bit
  // 8(i-1)+k one cycle later, one byte per cycle while the burst lasts.
  task automatic run_burst(input int tail);
    int n;
    int lock_i;
    int lock_k;
    int err_i;
    logic [7:0] b;
    n = bq.size();
    lock_i = -1;
    lock_k = 0;
    err_i  = -1;
    for (int i = 1; i < n && i <= TO && lock_i < 0; i++)
      for (int k = 0; k < 8 && lock_i < 0; k++)
        if (sbyte(8 * (i - 1) + k) == SYNC) begin
          lock_i = i;
          lock_k = k;
        end
    if (lock_i < 0 && n - 1 >= TO) err_i = TO;

    n_sot = 0; n_err = 0; n_val = 0;
    outq.delete();
    for (int c = 0; c < 2; c++) begin
      cyc(1'b0, 8'($urandom));
      chk("lp_valid", 8'(valid_o), 8'h00);
      chk("lp_locked", 8'(locked_o), 8'h00);
    end
    for (int c = 0; c < n + tail; c++) begin
      b = (c < n) ? bq[c] : 8'($urandom);
      cyc(c < n, b);
      if (c == lock_i) exp_off = 3'(lock_k);
      if (sot_o === 1'b1) n_sot++;
      if (sot_err_o === 1'b1) n_err++;
      if (valid_o === 1'b1) begin n_val++; outq.push_back(byte_o); end
      chk("sot", 8'(sot_o), 8'(c == lock_i));
      chk("sot_err", 8'(sot_err_o), 8'(c == err_i));
      chk("locked", 8'(locked_o), 8'(lock_i >= 0 && c >= lock_i && c < n));
      chk("valid", 8'(valid_o), 8'(lock_i >= 0 && c > lock_i && c < n));
      chk("offset", 8'(offset_o), 8'(exp_off));
      if (lock_i >= 0 && c > lock_i && c < n)
        chk("payload", byte_o, sbyte(8 * (c - 1) + lock_k));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte"}, byte_o, 8'h00);
    chk({tag, "_valid"}, 8'(valid_o), 8'h00);
    chk({tag, "_sot"}, 8'(sot_o), 8'h00);
    chk({tag, "_err"}, 8'(sot_err_o), 8'h00);
    chk({tag, "_locked"}, 8'(locked_o), 8'h00);
    chk({tag, "_offset"}, 8'(offset_o), 8'h00);
  endtask

  initial begin
    int n;
    int p;
    // Reset state.
    @(negedge clk_i);
    cyc(1'b0, 8'h00);
    chk_all_zero("reset");
    rst_n_i = 1'b1;

    // Offset 0.
    bq = '{8'h00, 8'h00, 8'hB8, 8'h11, 8'h22, 8'h33};
    run_burst(2);
    chk("off0_offset", 8'(offset_o), 8'd0);
    chk("off0_first", (outq.size() > 0) ? outq[0] : 8'hxx, 8'h11);
    chk("off0_second", (outq.size() > 1) ? outq[1] : 8'hxx, 8'h22);
    chk("off0_sot_count", 8'(n_sot), 8'd1);

    // Offset 3: sync straddles {8D,C0}.
    bq = '{8'h00, 8'hC0, 8'h8D, 8'h10, 8'h01};
    run_burst(2);
    chk("off3_offset", 8'(offset_o), 8'd3);
    chk("off3_first", (outq.size() > 0) ? outq[0] : 8'hxx, 8'h11);
    chk("off3_second", (outq.size() > 1) ? outq[1] : 8'hxx, 8'h22);

    // Timeout: 20 bytes of zeros.
    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'h00);
    run_burst(2);
    chk("to_err_count", 8'(n_err), 8'd1);
    chk("to_sot_count", 8'(n_sot), 8'd0);
    chk("to_valid_count", 8'(n_val), 8'd0);

    // Burst end mid-payload, then relock at offset 5 (0xB8<<5 = 0x1700).
    bq = '{8'h00, 8'h00, 8'hB8, 8'h5A, 8'hA5, 8'h3C, 8'hC3};
    run_burst(2);
    bq = '{8'h00, 8'h00, 8'h17, 8'hAA, 8'h55, 8'h0F};
    run_burst(2);
    chk("relock_offset", 8'(offset_o), 8'd5);
    chk("relock_sot_count", 8'(n_sot), 8'd1);

    // Sync at k=2 (0xB8<<2 = 0x2E0) followed by further sync bytes; the
    // earliest occurrence must win. B8 cannot match itself at two shifts of
    // one window, so a later duplicate is the nearest realisable case.
    bq = '{8'h00, 8'hE0, 8'h02, 8'hB8, 8'hB8, 8'h77};
    run_burst(2);
    chk("dbl_offset", 8'(offset_o), 8'd2);

    // Reset while locked: outputs clear before any clock edge.
    bq = '{8'h00, 8'hC0, 8'h8D, 8'h10, 8'h01, 8'h44, 8'h55};
    run_burst(0);
    chk("pre_rst_locked", 8'(locked_o), 8'h01);
    #2 rst_n_i = 1'b0;
    #1 chk_all_zero("async_rst");
    exp_off = 3'd0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    // hs_en_i still high with sync on the wire: must not hunt until LP seen.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, (i % 2 == 0) ? 8'h00 : 8'hB8);
      chk("norearm_sot", 8'(sot_o), 8'h00);
      chk("norearm_locked", 8'(locked_o), 8'h00);
      chk("norearm_valid", 8'(valid_o), 8'h00);
    end
    bq = '{8'h00, 8'h00, 8'hB8, 8'h66, 8'h99};
    run_burst(1);
    chk("post_rst_sot_count", 8'(n_sot), 8'd1);

    // Randomized bursts, most with a sync planted at a random bit position.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(4, 36);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        p = $urandom_range(0, 8 * n - 8);
        put_sync(p);
      end
      run_burst($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
